// File: rtl/pipelined_leading_one_normaliser.sv
// rtl/pipelined_leading_one_normaliser.sv - two-stage leading/trailing-one detector with normalising shifter
// Stage 1 locates the selected one, stage 2 shifts it to the MSB (mode 0) or bit 0 (mode 1).
module pipelined_leading_one_normaliser #(
   parameter int WIDTH = 10,
   parameter int LOC_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_word,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LOC_W-1:0] out_location,
   output logic [WIDTH-1:0] out_word,
   output logic             out_zero,
   output logic             out_mode
);

   logic             s1_valid;
   logic             s1_mode;
   logic [WIDTH-1:0] s1_word;
   logic [LOC_W-1:0] s1_loc;
   logic [LOC_W-1:0] in_loc;
   logic [LOC_W-1:0] shl_amt;
   logic [LOC_W-1:0] shr_amt;
   logic [WIDTH-1:0] s2_word;
   logic             s1_adv;
   logic             s2_adv;
   logic             accept;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_adv;
   assign in_ready = !s1_valid || s2_adv;
   assign accept   = in_valid && in_ready;

   // Scan order sets the priority: the last match visited by the loop wins
   always_comb begin
      in_loc = '0;
      if (in_mode) begin
         for (int i = WIDTH - 1; i >= 0; i--)
            if (in_word[i]) in_loc = LOC_W'(i + 1);
      end else begin
         for (int i = 0; i < WIDTH; i++)
            if (in_word[i]) in_loc = LOC_W'(i + 1);
      end
   end

   assign shl_amt = LOC_W'(WIDTH) - s1_loc;
   assign shr_amt = s1_loc - LOC_W'(1);

   // A zero location means an all-zero word, which bypasses the shifter
   always_comb begin
      s2_word = '0;
      if (s1_loc != '0)
         s2_word = s1_mode ? (s1_word >> shr_amt) : (s1_word << shl_amt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_word  <= '0;
         s1_loc   <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_mode  <= in_mode;
            s1_word  <= in_word;
            s1_loc   <= in_loc;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_location <= '0;
         out_word     <= '0;
         out_zero     <= 1'b0;
         out_mode     <= 1'b0;
      end else begin
         if (s2_adv)
            out_valid <= s1_valid;
         if (s1_adv) begin
            out_location <= s1_loc;
            out_word     <= s2_word;
            out_zero     <= (s1_loc == '0);
            out_mode     <= s1_mode;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_leading_one_normaliser.sv
// tb/tb_pipelined_leading_one_normaliser.sv - scoreboard bench for the leading-one normaliser
module tb_pipelined_leading_one_normaliser;

   localparam int W  = 10;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_word = '0;
   logic          in_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [LW-1:0] out_location;
   logic [W-1:0]  out_word;
   logic          out_zero;
   logic          out_mode;

   logic        d16_in_valid = 1'b0, d16_in_ready, d16_in_mode = 1'b0;
   logic [15:0] d16_in_word = '0, d16_out_word;
   logic        d16_out_valid, d16_out_zero, d16_out_mode;
   logic [4:0]  d16_out_location;

   logic        d2_in_valid = 1'b0, d2_in_ready, d2_in_mode = 1'b0;
   logic [1:0]  d2_in_word = '0, d2_out_word;
   logic        d2_out_valid, d2_out_zero, d2_out_mode;
   logic [1:0]  d2_out_location;

   pipelined_leading_one_normaliser #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_word(in_word), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_location(out_location), .out_word(out_word), .out_zero(out_zero), .out_mode(out_mode)
   );

   pipelined_leading_one_normaliser #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
      .in_word(d16_in_word), .in_mode(d16_in_mode), .out_valid(d16_out_valid), .out_ready(1'b1),
      .out_location(d16_out_location), .out_word(d16_out_word), .out_zero(d16_out_zero),
      .out_mode(d16_out_mode)
   );

   pipelined_leading_one_normaliser #(.WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
      .in_word(d2_in_word), .in_mode(d2_in_mode), .out_valid(d2_out_valid), .out_ready(1'b1),
      .out_location(d2_out_location), .out_word(d2_out_word), .out_zero(d2_out_zero),
      .out_mode(d2_out_mode)
   );

   typedef struct {
      logic [W-1:0]  word;
      logic          mode;
      logic [LW-1:0] loc;
      logic [W-1:0]  nword;
      logic          zero;
   } vec_t;

   typedef struct {
      logic [LW-1:0] loc;
      logic [W-1:0]  word;
      logic          zero;
      logic          mode;
   } exp_t;

   exp_t  sb[$];
   exp_t  pend;
   exp_t  mon_e;
   vec_t  vecs[11];
   int    checks = 0;
   int    errors = 0;
   int    ready_low = 0;
   int    popped = 0;
   bit    mon_en = 1'b0;
   bit    last_stall = 1'b0;
   logic [LW+W+1:0] last_out;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Independent model: normalise by single-bit shifts until the one reaches the edge
   function automatic void ref_norm(input int width, input logic [31:0] w, input logic m,
                                    output int loc, output logic [31:0] nw, output bit z);
      logic [31:0] mask = (32'h1 << width) - 32'h1;
      int sh = 0;
      nw  = w & mask;
      z   = (nw == 32'h0);
      loc = 0;
      if (!z) begin
         if (!m) begin
            while (!nw[width-1]) begin nw = (nw << 1) & mask; sh++; end
            loc = width - sh;
         end else begin
            while (!nw[0]) begin nw = nw >> 1; sh++; end
            loc = sh + 1;
         end
      end
   endfunction

   // Scoreboard: push on accept, pop on take, watch backpressure and stall stability
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         checks++;
         if (in_ready !== !(sb.size() == 2 && out_valid === 1'b1 && out_ready === 1'b0)) begin
            errors++;
            $display("FAIL in_ready got %b want %b (in flight %0d)", in_ready,
                     !(sb.size() == 2 && out_valid && !out_ready), sb.size());
         end
         if (!in_ready) ready_low++;
         if (last_stall) begin
            checks++;
            if ({out_valid, out_location, out_word, out_zero, out_mode} !== {1'b1, last_out}) begin
               errors++;
               $display("FAIL stall_hold got %h want %h",
                        {out_valid, out_location, out_word, out_zero, out_mode}, {1'b1, last_out});
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            popped++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat got loc %0d word %h want none", out_location, out_word);
            end else begin
               mon_e = sb.pop_front();
               if ({out_location, out_word, out_zero, out_mode} !==
                   {mon_e.loc, mon_e.word, mon_e.zero, mon_e.mode}) begin
                  errors++;
                  $display("FAIL beat got loc %0d word %h zero %b mode %b want loc %0d word %h zero %b mode %b",
                           out_location, out_word, out_zero, out_mode,
                           mon_e.loc, mon_e.word, mon_e.zero, mon_e.mode);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back(pend);
         last_stall = out_valid && !out_ready;
         last_out   = {out_location, out_word, out_zero, out_mode};
      end else begin
         last_stall = 1'b0;
      end
   end

   task automatic send(input logic [W-1:0] w, input logic m, input exp_t e);
      bit acc = 1'b0;
      in_word  = w;
      in_mode  = m;
      pend     = e;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("send_accept", acc, 1'b1);
   endtask

   task automatic send_ref(input logic [W-1:0] w, input logic m);
      int l;
      logic [31:0] nw;
      bit z;
      ref_norm(W, 32'(w), m, l, nw, z);
      send(w, m, '{loc: LW'(l), word: nw[W-1:0], zero: z, mode: m});
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
      chk(name, 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic lat_check(input string name, input logic [W-1:0] w, input logic m, input exp_t e);
      int n = 0;
      in_word  = w;
      in_mode  = m;
      pend     = e;
      in_valid = 1'b1;
      @(negedge clk);
      chk({name, "_accept"}, in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      chk({name, "_latency"}, 64'(n), 64'd2);
      drain({name, "_drain"});
   endtask

   task automatic wide_beat(input int width, input logic [15:0] w, input logic m);
      int eloc;
      logic [31:0] enw;
      bit ez;
      int n = 0;
      bit gv = 1'b0;
      ref_norm(width, {16'h0, w}, m, eloc, enw, ez);
      if (width == 16) begin
         d16_in_word = w; d16_in_mode = m; d16_in_valid = 1'b1;
      end else begin
         d2_in_word = w[1:0]; d2_in_mode = m; d2_in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      d16_in_valid = 1'b0;
      d2_in_valid  = 1'b0;
      while (!gv && n < 10) begin
         @(negedge clk);
         n++;
         gv = (width == 16) ? d16_out_valid : d2_out_valid;
      end
      if (width == 16)
         chk($sformatf("w16_%h_m%0d", w, m),
             {gv, 8'(n), 8'(d16_out_location), d16_out_word, d16_out_zero, d16_out_mode},
             {1'b1, 8'd2, 8'(eloc), enw[15:0], ez, m});
      else
         chk($sformatf("w2_%h_m%0d", w, m),
             {gv, 8'(n), 8'(d2_out_location), 14'h0, d2_out_word, d2_out_zero, d2_out_mode},
             {1'b1, 8'd2, 8'(eloc), enw[15:0], ez, m});
   endtask

   initial begin
      vecs[0]  = '{10'h02C, 1'b0, 4'd6,  10'h2C0, 1'b0};
      vecs[1]  = '{10'h02C, 1'b1, 4'd3,  10'h00B, 1'b0};
      vecs[2]  = '{10'h200, 1'b1, 4'd10, 10'h001, 1'b0};
      vecs[3]  = '{10'h000, 1'b0, 4'd0,  10'h000, 1'b1};
      vecs[4]  = '{10'h000, 1'b1, 4'd0,  10'h000, 1'b1};
      vecs[5]  = '{10'h3FF, 1'b0, 4'd10, 10'h3FF, 1'b0};
      vecs[6]  = '{10'h3FF, 1'b1, 4'd1,  10'h3FF, 1'b0};
      vecs[7]  = '{10'h001, 1'b0, 4'd1,  10'h200, 1'b0};
      vecs[8]  = '{10'h200, 1'b0, 4'd10, 10'h200, 1'b0};
      vecs[9]  = '{10'h0A0, 1'b1, 4'd6,  10'h005, 1'b0};
      vecs[10] = '{10'h0A0, 1'b0, 4'd8,  10'h280, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {out_valid, out_location, out_word, out_zero, out_mode}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      lat_check("first", 10'h02C, 1'b0, '{loc: 4'd6, word: 10'h2C0, zero: 1'b0, mode: 1'b0});

      for (int i = 0; i < 11; i++)
         send(vecs[i].word, vecs[i].mode,
              '{loc: vecs[i].loc, word: vecs[i].nword, zero: vecs[i].zero, mode: vecs[i].mode});
      drain("table_drain");

      ready_low = 0;
      popped    = 0;
      fork
         for (int k = 0; k < 8; k++) send_ref(W'($urandom_range(0, 1023)), 1'(k % 2));
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain("stall_drain");
      chk("stall_backpressure", 64'(ready_low > 0), 64'd1);
      chk("stall_count", 64'(popped), 64'd8);

      out_ready = 1'b0;
      send_ref(10'h155, 1'b0);
      send_ref(10'h0F0, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_outputs", {out_valid, out_location, out_word, out_zero, out_mode}, 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_stale_beat", out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      lat_check("post_reset", 10'h040, 1'b1, '{loc: 4'd7, word: 10'h001, zero: 1'b0, mode: 1'b1});

      for (int i = 0; i < 16; i++)
         for (int m = 0; m < 2; m++) wide_beat(16, 16'h1 << i, 1'(m));
      for (int i = 0; i < 6; i++)
         for (int m = 0; m < 2; m++) wide_beat(16, 16'($urandom_range(0, 65535)), 1'(m));
      wide_beat(16, 16'h0, 1'b0);
      for (int i = 0; i < 4; i++)
         for (int m = 0; m < 2; m++) wide_beat(2, 16'(i), 1'(m));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
